// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler sharing one UART transmitter among four producers
// Launches one byte at a time and holds a per-producer packet lock until the last byte is sent.
module uart_tx_sched #(
   parameter int NREQ = 4,
   parameter int TMO  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     ack,
   output logic [7:0]          tx_data,
   output logic                tx_start,
   input  logic                tx_busy,
   output logic [1:0]          owner,
   output logic                active,
   output logic                err,
   output logic [15:0]         byte_cnt
);

   localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_BUSY = 2'd1;
   localparam logic [1:0] S_WAIT_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [1:0]      owner_q, owner_d;
   logic            lock_q, lock_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            active_q, active_d;
   logic            err_q, err_d;
   logic [15:0]     byte_cnt_q, byte_cnt_d;

   logic            found;
   logic [1:0]      sel;
   logic [1:0]      idx;
   logic            launch;
   logic [1:0]      launch_id;

   // First requesting slot found scanning upward from ptr, wrapping at 4.
   always_comb begin
      found = 1'b0;
      sel   = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      lock_d     = lock_q;
      timer_d    = timer_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      ack_d      = '0;
      err_d      = 1'b0;
      byte_cnt_d = byte_cnt_q;
      launch     = 1'b0;
      launch_id  = sel;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               launch    = 1'b1;
               launch_id = sel;
            end
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (timer_q == TW'(TMO - 1)) begin
               err_d   = 1'b1;
               lock_d  = 1'b0;
               ptr_d   = owner_q + 2'd1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               byte_cnt_d = byte_cnt_q + 16'd1;
               // A locked owner that still has a byte skips arbitration entirely.
               if (lock_q && req[owner_q]) begin
                  launch    = 1'b1;
                  launch_id = owner_q;
               end else begin
                  lock_d  = 1'b0;
                  ptr_d   = owner_q + 2'd1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         tx_data_d  = req_data[{launch_id, 3'b000} +: 8];
         tx_start_d = 1'b1;
         ack_d      = NREQ'(1) << launch_id;
         owner_d    = launch_id;
         lock_d     = ~req_last[launch_id];
         timer_d    = '0;
         state_d    = S_WAIT_BUSY;
      end

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= 2'd0;
         owner_q    <= 2'd0;
         lock_q     <= 1'b0;
         timer_q    <= '0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
         byte_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         lock_q     <= lock_d;
         timer_q    <= timer_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         ack_q      <= ack_d;
         active_q   <= active_d;
         err_q      <= err_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign ack      = ack_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign owner    = owner_q;
   assign active   = active_q;
   assign err      = err_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench for uart_tx_sched with producer and transmitter models
module tb_uart_tx_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  owner;
   logic        active;
   logic        err;
   logic [15:0] byte_cnt;

   uart_tx_sched #(.NREQ(4), .TMO(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .owner(owner), .active(active), .err(err), .byte_cnt(byte_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int busy_len = 10;
   logic stuck = 1'b0;

   // Pending producer bytes: {id[1:0], last, data[7:0]}
   logic [10:0] pend[$];

   logic [7:0]  l_data[$];
   logic [3:0]  l_ack[$];
   logic [1:0]  l_owner[$];
   logic [15:0] l_cnt[$];
   int          l_cyc[$];
   int          stray_ack = 0;
   int          err_cnt = 0;
   int          err_cyc = 0;
   logic        err_active = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] d, input logic last);
      logic [1:0] i2;
      i2 = 2'(id);
      pend.push_back({i2, last, d});
   endtask

   task automatic wait_launches(input int n);
      int t;
      t = 0;
      while (l_data.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (l_data.size() < n) chk("launch_timeout", l_data.size(), n);
   endtask

   task automatic exp_launch(input string tag, input int i, input logic [7:0] d,
                             input logic [3:0] a, input logic [1:0] o);
      wait_launches(i + 1);
      if (l_data.size() > i) begin
         chk({tag, "_data"}, l_data[i], d);
         chk({tag, "_ack"}, l_ack[i], a);
         chk({tag, "_owner"}, l_owner[i], o);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (t < 3000 && (pend.size() != 0 || active || tx_busy || tx_start || req != 0));
      if (t >= 3000) chk("idle_timeout", t, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_busy(input logic lvl);
      int t;
      t = 0;
      while (tx_busy !== lvl && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("busy_timeout", tx_busy, lvl);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Producers: each id drives its oldest pending byte and pops it on ack.
   initial begin
      logic [3:0]  r;
      logic [31:0] d;
      logic [3:0]  l;
      int          id;
      req = '0;
      req_data = '0;
      req_last = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
               for (int j = 0; j < pend.size(); j++) begin
                  if (int'(pend[j][10:9]) == i) begin
                     pend.delete(j);
                     break;
                  end
               end
            end
         end
         r = '0;
         d = '0;
         l = '0;
         for (int j = pend.size() - 1; j >= 0; j--) begin
            id = int'(pend[j][10:9]);
            r[id] = 1'b1;
            d[id*8 +: 8] = pend[j][7:0];
            l[id] = pend[j][8];
         end
         req = r;
         req_data = d;
         req_last = l;
      end
   end

   // Transmitter: busy rises one cycle after the start strobe and stays for busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1 && !stuck) begin
            @(negedge clk);
            tx_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
         l_data.push_back(tx_data);
         l_ack.push_back(ack);
         l_owner.push_back(owner);
         l_cnt.push_back(byte_cnt);
         l_cyc.push_back(cyc);
      end else if (ack !== 4'b0000) begin
         stray_ack++;
      end
      if (err === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
         err_active = active;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int b;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 4'h0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_owner", owner, 2'd0);
      chk("rst_active", active, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_byte_cnt", byte_cnt, 16'h0000);
      rst = 1'b1;
      @(negedge clk);

      // Single byte
      b = l_data.size();
      push(0, 8'h55, 1'b1);
      exp_launch("single", b, 8'h55, 4'b0001, 2'd0);
      wait_idle();
      chk("single_cnt", byte_cnt, 16'd1);
      chk("single_active", active, 1'b0);

      // Round robin with all four requesting (ptr is 1 after the single byte)
      b = l_data.size();
      push(0, 8'hA0, 1'b1);
      wait_launches(b + 1);
      push(1, 8'hA1, 1'b1);
      push(2, 8'hA2, 1'b1);
      push(3, 8'hA3, 1'b1);
      push(0, 8'hA0, 1'b1);
      exp_launch("rr0", b,     8'hA0, 4'b0001, 2'd0);
      exp_launch("rr1", b + 1, 8'hA1, 4'b0010, 2'd1);
      exp_launch("rr2", b + 2, 8'hA2, 4'b0100, 2'd2);
      exp_launch("rr3", b + 3, 8'hA3, 4'b1000, 2'd3);
      exp_launch("rr4", b + 4, 8'hA0, 4'b0001, 2'd0);
      if (l_cyc.size() > b + 2) chk("rr_gap", l_cyc[b+2] - l_cyc[b+1], 13);
      wait_idle();
      chk("rr_cnt", byte_cnt, 16'd6);

      // Packet lock from req0 while req2 waits
      b = l_data.size();
      push(0, 8'h10, 1'b0);
      push(0, 8'h11, 1'b0);
      push(0, 8'h12, 1'b1);
      wait_launches(b + 1);
      push(2, 8'h20, 1'b1);
      exp_launch("lock0", b,     8'h10, 4'b0001, 2'd0);
      exp_launch("lock1", b + 1, 8'h11, 4'b0001, 2'd0);
      exp_launch("lock2", b + 2, 8'h12, 4'b0001, 2'd0);
      exp_launch("lock3", b + 3, 8'h20, 4'b0100, 2'd2);
      if (l_cyc.size() > b + 3) begin
         chk("lock_gap1", l_cyc[b+1] - l_cyc[b], 12);
         chk("lock_gap2", l_cyc[b+2] - l_cyc[b+1], 12);
         chk("lock_gap3", l_cyc[b+3] - l_cyc[b+2], 13);
      end
      wait_idle();
      chk("lock_cnt", byte_cnt, 16'd10);

      // Lock withdrawal: req1 leaves the lock set but drops req
      b = l_data.size();
      push(1, 8'h31, 1'b0);
      wait_launches(b + 1);
      push(3, 8'h33, 1'b1);
      exp_launch("wd0", b,     8'h31, 4'b0010, 2'd1);
      exp_launch("wd1", b + 1, 8'h33, 4'b1000, 2'd3);
      if (l_cnt.size() > b + 1) chk("wd_cnt_mid", l_cnt[b+1], 16'd11);
      if (l_cyc.size() > b + 1) chk("wd_gap", l_cyc[b+1] - l_cyc[b], 13);
      wait_idle();
      chk("wd_cnt", byte_cnt, 16'd12);

      // Watchdog with a dead transmitter
      stuck = 1'b1;
      b = l_data.size();
      push(0, 8'h77, 1'b1);
      exp_launch("tmo", b, 8'h77, 4'b0001, 2'd0);
      repeat (30) @(negedge clk);
      chk("tmo_err_cnt", err_cnt, 1);
      if (l_cyc.size() > b) chk("tmo_delay", err_cyc - l_cyc[b], 16);
      chk("tmo_active", err_active, 1'b0);
      chk("tmo_byte_cnt", byte_cnt, 16'd12);
      stuck = 1'b0;
      b = l_data.size();
      push(0, 8'h78, 1'b1);
      push(1, 8'h79, 1'b1);
      exp_launch("tmo_ptr0", b,     8'h79, 4'b0010, 2'd1);
      exp_launch("tmo_ptr1", b + 1, 8'h78, 4'b0001, 2'd0);
      wait_idle();
      chk("tmo_cnt_after", byte_cnt, 16'd14);

      // Counter wrap from a preloaded 0xFFFF
      force dut.byte_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.byte_cnt_q;
      @(negedge clk);
      chk("wrap_pre", byte_cnt, 16'hFFFF);
      push(2, 8'h5A, 1'b1);
      wait_idle();
      chk("wrap_post", byte_cnt, 16'h0000);

      // Reset during WAIT_DONE, with ptr sitting at 3
      b = l_data.size();
      push(2, 8'h6B, 1'b1);
      wait_launches(b + 1);
      wait_busy(1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ack", ack, 4'h0);
      chk("mid_rst_tx_start", tx_start, 1'b0);
      chk("mid_rst_tx_data", tx_data, 8'h00);
      chk("mid_rst_owner", owner, 2'd0);
      chk("mid_rst_active", active, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_byte_cnt", byte_cnt, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      wait_busy(1'b0);
      repeat (2) @(negedge clk);
      b = l_data.size();
      push(0, 8'h0A, 1'b1);
      push(3, 8'h3C, 1'b1);
      exp_launch("post_rst0", b,     8'h0A, 4'b0001, 2'd0);
      exp_launch("post_rst1", b + 1, 8'h3C, 4'b1000, 2'd3);
      wait_idle();
      b = l_data.size();
      push(3, 8'h3D, 1'b1);
      exp_launch("post_rst3", b, 8'h3D, 4'b1000, 2'd3);
      wait_idle();
      chk("post_rst_cnt", byte_cnt, 16'd3);

      chk("stray_ack", stray_ack, 0);
      chk("err_total", err_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
